// File: rtl/sneg_pkg.sv
// Shared types and helpers for the serial negate controller.
`timescale 1ns/1ps
package sneg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for a given word width: $clog2(w), never below 1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_negate_ctrl_if.sv
// Word-in / word-out bus of the serial negate controller.
// Optional signal out_ovf exists only when SNEG_OVF_DETECT_EN is defined.
`timescale 1ns/1ps
interface serial_negate_ctrl_if #(
  parameter int WIDTH = 8
);
  // Handshake: a word moves on a rising t_clk edge where valid & ready are
  // both high. The source holds valid and data stable until that edge; ready
  // never depends on valid (in_ready is a function of controller state only).
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef SNEG_OVF_DETECT_EN
  logic             out_ovf;
`endif
  sneg_pkg::state_t fsm_state;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy,
`ifdef SNEG_OVF_DETECT_EN
    output out_ovf,
`endif
    output fsm_state
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy,
`ifdef SNEG_OVF_DETECT_EN
    input  out_ovf,
`endif
    input  fsm_state
  );
endinterface

// File: rtl/serial_tc_cell.sv
// Bit-serial two's-complement cell: passes bits unchanged up to and including
// the first one, then inverts every later bit.
`timescale 1ns/1ps
module serial_tc_cell (
  input  logic t_clk,
  input  logic r,
  input  logic clr,
  input  logic en,
  input  logic i,
  output logic y
);
  logic flag;

  assign y = i ^ flag;

  // Seen-one flag: cleared at word start, sticky once a one has passed.
  always_ff @(posedge t_clk or posedge r) begin
    if (r)        flag <= 1'b0;
    else if (clr) flag <= 1'b0;
    else if (en)  flag <= flag | i;
  end
endmodule

// File: rtl/serial_negate_ctrl.sv
// Sequencer around serial_tc_cell: accepts a word, streams it LSB-first
// through the cell and returns -x mod 2^WIDTH.
// Optional feature macro: SNEG_OVF_DETECT_EN (adds out_ovf for x = 100..0).
`timescale 1ns/1ps
module serial_negate_ctrl
  import sneg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 t_clk,
  input  logic                 r,
  serial_negate_ctrl_if.slave  bus
);
  localparam int CW = cnt_w(WIDTH);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST_CNT = cnt_t'(WIDTH - 1);

  state_t           state, state_nxt;
  cnt_t             cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             load, shift_en, last, xfer;
  logic             cell_y;

  serial_tc_cell u_cell (
    .t_clk (t_clk),
    .r     (r),
    .clr   (load),
    .en    (shift_en),
    .i     (sreg[0]),
    .y     (cell_y)
  );

  // Result fills from the MSB side so the LSB-first stream lands in place.
  assign res_nxt = (res >> 1) | (WIDTH'(cell_y) << (WIDTH - 1));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = res;
  assign bus.fsm_state = state;

  // FSM state register.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) state <= IDLE;
    else   state <= state_nxt;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    last      = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          xfer      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shift registers and bit counter; counter holds on the last bit.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      cnt  <= '0;
      sreg <= '0;
      res  <= '0;
    end else if (load) begin
      cnt  <= '0;
      sreg <= bus.in_data;
    end else if (shift_en) begin
      sreg <= sreg >> 1;
      res  <= res_nxt;
      if (!last) cnt <= cnt + cnt_t'(1);
    end
  end

`ifdef SNEG_OVF_DETECT_EN
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
  logic ovf;

  assign bus.out_ovf = ovf;

  // Only 100..0 negates to itself with the MSB set, so test the final result.
  always_ff @(posedge t_clk or posedge r) begin
    if (r)                  ovf <= 1'b0;
    else if (shift_en && last) ovf <= (res_nxt == MIN_NEG);
    else if (xfer)          ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Self-checking bench for serial_negate_ctrl (WIDTH=8, 156 ns clock).
// Build with or without SNEG_OVF_DETECT_EN.
`timescale 1ns/1ps
module tb_serial_negate_ctrl;
  import sneg_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic t_clk = 1'b0;
  logic r     = 1'b1;
  always #78 t_clk = ~t_clk;

  serial_negate_ctrl_if #(.WIDTH(W)) bus ();

  serial_negate_ctrl #(.WIDTH(W)) dut (
    .t_clk (t_clk),
    .r     (r),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc      = 0;
  logic [W-1:0] exp_q[$];
  logic         model_busy = 1'b0;
  logic         prev_valid = 1'b0;
  logic         seen_valid = 1'b0;
  logic [W-1:0] prev_data  = '0;
  int unsigned  acc_edge   = 0;
  logic         rand_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: two's-complement negation by plain modular arithmetic.
  function automatic logic [W-1:0] model_neg(input logic [W-1:0] x);
    int unsigned full;
    full = 32'd1 << W;
    return W'((full - 32'(x)) % full);
  endfunction

  always @(posedge t_clk) cyc <= cyc + 1;

  always @(posedge t_clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: sampled mid-cycle; a handshake seen here happens on the next rising edge.
  always @(negedge t_clk) begin
    if (r) begin
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
      exp_q.delete();
      model_busy = 1'b0;
      prev_valid = 1'b0;
      seen_valid = 1'b0;
    end else begin
      check_eq("busy", 32'(bus.busy), 32'(model_busy));
      check_eq("in_ready", 32'(bus.in_ready), 32'(!model_busy));
`ifdef SNEG_OVF_DETECT_EN
      if (!bus.out_valid) check_eq("ovf_idle", 32'(bus.out_ovf), 32'd0);
`endif
      if (prev_valid) begin
        check_eq("valid_hold", 32'(bus.out_valid), 32'd1);
        check_eq("data_hold", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 32'd1, 32'd0);
        end else if (!seen_valid) begin
          // out_valid rises WIDTH edges after the accept edge (WIDTH+1 counting it).
          check_eq("latency", cyc - acc_edge, 32'(W));
        end
        seen_valid = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() != 0) begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check_eq("out_data", 32'(bus.out_data), 32'(e));
`ifdef SNEG_OVF_DETECT_EN
          check_eq("out_ovf", 32'(bus.out_ovf), 32'(e == 8'h80));
`endif
        end
        model_busy = 1'b0;
        prev_valid = 1'b0;
        seen_valid = 1'b0;
      end else begin
        prev_valid = bus.out_valid;
        prev_data  = bus.out_data;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model_neg(bus.in_data));
        model_busy = 1'b1;
        acc_edge   = cyc + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] x);
    bit got;
    got = 1'b0;
    @(posedge t_clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    for (int i = 0; i < 300; i++) begin
      @(negedge t_clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_eq("accept_timeout", 32'd1, 32'd0);
    @(posedge t_clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge t_clk); #2;
      if (!model_busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("idle_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] dir_words[4];
    int unsigned  acc_cyc[2];
    int           n_acc;
    bit           seen;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    r             = 1'b1;

    // Reset state.
    repeat (2) @(negedge t_clk);
    check_eq("rst_state", 32'(bus.fsm_state), 32'(IDLE));
`ifdef SNEG_OVF_DETECT_EN
    check_eq("rst_ovf", 32'(bus.out_ovf), 32'd0);
`endif
    @(posedge t_clk); #1;
    r = 1'b0;
    @(negedge t_clk);
    check_eq("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Directed words, consumer always ready.
    dir_words[0] = 8'h05; dir_words[1] = 8'h00;
    dir_words[2] = 8'hFF; dir_words[3] = 8'h80;
    foreach (dir_words[k]) begin
      send_word(dir_words[k]);
      wait_idle();
    end

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    send_word(8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge t_clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("bp_valid_seen", 32'(seen), 32'd1);
    repeat (5) begin
      @(negedge t_clk);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_data", 32'(bus.out_data), 32'h0000_00A6);
    end
    @(posedge t_clk); #1;
    bus.out_ready = 1'b1;
    @(posedge t_clk); #1;
    check_eq("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    check_eq("bp_ready_back", 32'(bus.in_ready), 32'd1);

    // Reset while bit 3 of 8'h36 is next to shift.
    send_word(8'h36);
    repeat (3) @(posedge t_clk);
    #1;
    r = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_data", 32'(bus.out_data), 32'd0);
    check_eq("mid_rst_state", 32'(bus.fsm_state), 32'(IDLE));
    @(negedge t_clk);
    @(posedge t_clk); #1;
    r = 1'b0;
    send_word(8'h01);
    wait_idle();

    // Back-to-back with in_valid and out_ready held high.
    n_acc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    for (int i = 0; i < 100 && n_acc < 2; i++) begin
      @(negedge t_clk);
      if (bus.in_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        @(posedge t_clk); #1;
        if (n_acc == 2) bus.in_valid = 1'b0;
        else            bus.in_data  = 8'h7F;
      end
    end
    bus.in_valid = 1'b0;
    check_eq("b2b_accepts", 32'(n_acc), 32'd2);
    if (n_acc == 2) check_eq("b2b_spacing", acc_cyc[1] - acc_cyc[0], 32'(W + 2));
    wait_idle();

    // Randomized words with random consumer stalls and idle gaps.
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] x;
      case ($urandom_range(0, 9))
        0:       x = 8'h00;
        1:       x = 8'h80;
        2:       x = 8'hFF;
        3:       x = 8'h01;
        default: x = W'($urandom);
      endcase
      send_word(x);
      repeat ($urandom_range(0, 3)) @(posedge t_clk);
    end
    rand_ready = 1'b0;
    @(posedge t_clk); #2;
    bus.out_ready = 1'b1;
    wait_idle();

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
